// File: rtl/slice_serializer.sv
// Streaming bit-slice serializer: one WIDTH-bit word in, NSLICES SLICE-bit slices out.
// Optional macro SLICE_SERIALIZER_MSB_FIRST_EN: emit the top (padded) slice first.
module slice_serializer #(
    parameter int unsigned  WIDTH   = 8,
    parameter int unsigned  SLICE   = 4,
    localparam int unsigned NSLICES = (WIDTH + SLICE - 1) / SLICE,
    localparam int unsigned IDXW    = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SLICE-1:0]  out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_index,
    output logic              out_last,
    output logic              busy
);

    localparam int unsigned PADW = NSLICES * SLICE;
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    localparam int unsigned FIRST_K = NSLICES - 1;
`else
    localparam int unsigned FIRST_K = 0;
`endif
    localparam logic [IDXW-1:0] FIRST_IDX   = IDXW'(FIRST_K);
    localparam int unsigned     FIRST_SHIFT = FIRST_K * SLICE;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t            r_state;
    logic [PADW-1:0]   r_word;

    logic [PADW-1:0]   w_in_pad;
    logic [IDXW-1:0]   w_next_idx;
    logic [SLICE-1:0]  w_first_slice;
    logic [SLICE-1:0]  w_next_slice;
    logic              w_capture;
    logic              w_advance;
    logic              w_drain;

    // Handshake decode; in_ready is the only combinational output (out_ready -> in_ready).
    always_comb begin
        w_in_pad      = PADW'(in_data);
        in_ready      = !rst && ((r_state == S_IDLE) || (out_last && out_ready));
        w_capture     = in_valid && in_ready;
        w_advance     = (r_state == S_SEND) && out_ready && !out_last;
        w_drain       = (r_state == S_SEND) && out_ready && out_last && !in_valid;
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
        w_next_idx    = out_index - IDXW'(1);
`else
        w_next_idx    = out_index + IDXW'(1);
`endif
        w_first_slice = SLICE'(w_in_pad >> FIRST_SHIFT);
        w_next_slice  = SLICE'(r_word >> (32'(w_next_idx) * SLICE));
    end

    // State and registered outputs; the zero-padded word is kept so any slice is a plain shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_word    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else if (w_capture) begin
            r_state   <= S_SEND;
            r_word    <= w_in_pad;
            out_data  <= w_first_slice;
            out_valid <= 1'b1;
            out_index <= FIRST_IDX;
            out_last  <= (NSLICES == 1);
        end else if (w_advance) begin
            out_data  <= w_next_slice;
            out_index <= w_next_idx;
`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
            out_last  <= (w_next_idx == '0);
`else
            out_last  <= (w_next_idx == IDXW'(NSLICES - 1));
`endif
        end else if (w_drain) begin
            r_state   <= S_IDLE;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
        end
    end

    assign busy = out_valid;

endmodule

// File: tb/tb_slice_serializer.sv
// Directed bench for slice_serializer: 8/4 cycle table, 10/4 padded word with backpressure, 4/4 single-slice case.
module tb_slice_serializer;

`ifdef SLICE_SERIALIZER_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // DUT A: WIDTH=8, SLICE=4
    logic       a_rst, a_iv, a_ir, a_ov, a_ordy, a_ol, a_busy;
    logic [7:0] a_id;
    logic [3:0] a_od;
    logic [0:0] a_oi;
    // DUT B: WIDTH=10, SLICE=4
    logic       b_rst, b_iv, b_ir, b_ov, b_ordy, b_ol, b_busy;
    logic [9:0] b_id;
    logic [3:0] b_od;
    logic [1:0] b_oi;
    // DUT C: WIDTH=4, SLICE=4
    logic       c_rst, c_iv, c_ir, c_ov, c_ordy, c_ol, c_busy;
    logic [3:0] c_id;
    logic [3:0] c_od;
    logic [0:0] c_oi;

    slice_serializer #(.WIDTH(8), .SLICE(4)) u_a (
        .clk(clk), .rst(a_rst), .in_data(a_id), .in_valid(a_iv), .in_ready(a_ir),
        .out_data(a_od), .out_valid(a_ov), .out_ready(a_ordy), .out_index(a_oi),
        .out_last(a_ol), .busy(a_busy));

    slice_serializer #(.WIDTH(10), .SLICE(4)) u_b (
        .clk(clk), .rst(b_rst), .in_data(b_id), .in_valid(b_iv), .in_ready(b_ir),
        .out_data(b_od), .out_valid(b_ov), .out_ready(b_ordy), .out_index(b_oi),
        .out_last(b_ol), .busy(b_busy));

    slice_serializer #(.WIDTH(4), .SLICE(4)) u_c (
        .clk(clk), .rst(c_rst), .in_data(c_id), .in_valid(c_iv), .in_ready(c_ir),
        .out_data(c_od), .out_valid(c_ov), .out_ready(c_ordy), .out_index(c_oi),
        .out_last(c_ol), .busy(c_busy));

    typedef struct {
        logic       rst;
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       ov;
        logic [3:0] od_lsb;
        logic [3:0] od_msb;
        logic       oi_lsb;
        logic       ol;
        logic       ir;
    } vec_t;

    vec_t tbl[18];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic r, logic iv, logic [7:0] id, logic ordy, logic ov,
                                logic [3:0] odl, logic [3:0] odm, logic oil, logic ol, logic ir);
        vec_t v;
        v.rst = r; v.iv = iv; v.id = id; v.ordy = ordy; v.ov = ov;
        v.od_lsb = odl; v.od_msb = odm; v.oi_lsb = oil; v.ol = ol; v.ir = ir;
        return v;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    logic [3:0] exp_bd[3];
    logic [1:0] exp_bi[3];
    logic       exp_oi;

    initial begin
        //            rst iv  id     ordy ov  odL   odM   oiL  ol   ir
        tbl[0]  = mk(1, 0, 8'h00, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 8'hA5, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[2]  = mk(0, 0, 8'h00, 1, 1, 4'h5, 4'hA, 0, 0, 0);
        tbl[3]  = mk(0, 0, 8'h00, 1, 1, 4'hA, 4'h5, 1, 1, 1);
        tbl[4]  = mk(0, 0, 8'h00, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[5]  = mk(0, 1, 8'h12, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[6]  = mk(0, 1, 8'h34, 1, 1, 4'h2, 4'h1, 0, 0, 0);
        tbl[7]  = mk(0, 1, 8'h34, 1, 1, 4'h1, 4'h2, 1, 1, 1);
        tbl[8]  = mk(0, 0, 8'h00, 1, 1, 4'h4, 4'h3, 0, 0, 0);
        tbl[9]  = mk(0, 0, 8'h00, 1, 1, 4'h3, 4'h4, 1, 1, 1);
        tbl[10] = mk(0, 1, 8'hA5, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[11] = mk(0, 0, 8'h00, 1, 1, 4'h5, 4'hA, 0, 0, 0);
        tbl[12] = mk(1, 0, 8'h00, 0, 1, 4'hA, 4'h5, 1, 1, 0);
        tbl[13] = mk(0, 1, 8'h5A, 1, 0, 4'h0, 4'h0, 0, 0, 1);
        tbl[14] = mk(0, 0, 8'h00, 1, 1, 4'hA, 4'h5, 0, 0, 0);
        tbl[15] = mk(0, 0, 8'h00, 1, 1, 4'h5, 4'hA, 1, 1, 1);
        tbl[16] = mk(1, 1, 8'hFF, 1, 0, 4'h0, 4'h0, 0, 0, 0);
        tbl[17] = mk(0, 0, 8'h00, 1, 0, 4'h0, 4'h0, 0, 0, 1);

        if (MSB) begin
            exp_bd[0] = 4'h3; exp_bd[1] = 4'hC; exp_bd[2] = 4'h7;
            exp_bi[0] = 2'd2; exp_bi[1] = 2'd1; exp_bi[2] = 2'd0;
        end else begin
            exp_bd[0] = 4'h7; exp_bd[1] = 4'hC; exp_bd[2] = 4'h3;
            exp_bi[0] = 2'd0; exp_bi[1] = 2'd1; exp_bi[2] = 2'd2;
        end

        a_rst = 1; a_iv = 0; a_id = '0; a_ordy = 1;
        b_rst = 1; b_iv = 0; b_id = '0; b_ordy = 1;
        c_rst = 1; c_iv = 0; c_id = '0; c_ordy = 1;
        next_cycle();
        b_rst = 0; c_rst = 0;

        // DUT A: cycle table (reset, single word, back-to-back, reset mid-word, reset beats in_valid)
        for (int i = 0; i < 18; i++) begin
            a_rst = tbl[i].rst; a_iv = tbl[i].iv; a_id = tbl[i].id; a_ordy = tbl[i].ordy;
            #1;
            exp_oi = (MSB && tbl[i].ov) ? !tbl[i].oi_lsb : tbl[i].oi_lsb;
            chk($sformatf("a[%0d].out_valid", i), 32'(a_ov), 32'(tbl[i].ov));
            chk($sformatf("a[%0d].out_data", i), 32'(a_od), 32'(MSB ? tbl[i].od_msb : tbl[i].od_lsb));
            chk($sformatf("a[%0d].out_index", i), 32'(a_oi), 32'(exp_oi));
            chk($sformatf("a[%0d].out_last", i), 32'(a_ol), 32'(tbl[i].ol));
            chk($sformatf("a[%0d].in_ready", i), 32'(a_ir), 32'(tbl[i].ir));
            chk($sformatf("a[%0d].busy", i), 32'(a_busy), 32'(tbl[i].ov));
            next_cycle();
        end
        a_iv = 0; a_rst = 0;

        // DUT B: padded 10-bit word with 5 cycles of backpressure on the middle slice
        b_iv = 1; b_id = 10'h3C7; b_ordy = 1;
        #1;
        chk("b.idle_in_ready", 32'(b_ir), 32'd1);
        chk("b.idle_out_valid", 32'(b_ov), 32'd0);
        next_cycle();
        b_iv = 0;
        #1;
        chk("b.s0.out_valid", 32'(b_ov), 32'd1);
        chk("b.s0.out_data", 32'(b_od), 32'(exp_bd[0]));
        chk("b.s0.out_index", 32'(b_oi), 32'(exp_bi[0]));
        chk("b.s0.out_last", 32'(b_ol), 32'd0);
        chk("b.s0.in_ready", 32'(b_ir), 32'd0);
        next_cycle();
        b_ordy = 0; b_iv = 1; b_id = 10'h155;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("b.stall%0d.out_valid", k), 32'(b_ov), 32'd1);
            chk($sformatf("b.stall%0d.out_data", k), 32'(b_od), 32'(exp_bd[1]));
            chk($sformatf("b.stall%0d.out_index", k), 32'(b_oi), 32'(exp_bi[1]));
            chk($sformatf("b.stall%0d.out_last", k), 32'(b_ol), 32'd0);
            chk($sformatf("b.stall%0d.in_ready", k), 32'(b_ir), 32'd0);
            next_cycle();
        end
        b_ordy = 1; b_iv = 0;
        #1;
        chk("b.s1.out_data", 32'(b_od), 32'(exp_bd[1]));
        chk("b.s1.out_index", 32'(b_oi), 32'(exp_bi[1]));
        chk("b.s1.in_ready", 32'(b_ir), 32'd0);
        next_cycle();
        #1;
        chk("b.s2.out_valid", 32'(b_ov), 32'd1);
        chk("b.s2.out_data", 32'(b_od), 32'(exp_bd[2]));
        chk("b.s2.out_index", 32'(b_oi), 32'(exp_bi[2]));
        chk("b.s2.out_last", 32'(b_ol), 32'd1);
        chk("b.s2.in_ready", 32'(b_ir), 32'd1);
        next_cycle();
        #1;
        chk("b.end.out_valid", 32'(b_ov), 32'd0);
        chk("b.end.out_data", 32'(b_od), 32'd0);
        chk("b.end.out_index", 32'(b_oi), 32'd0);
        chk("b.end.in_ready", 32'(b_ir), 32'd1);

        // DUT C: single slice, acts as a one-deep register slice
        c_iv = 1; c_id = 4'h9; c_ordy = 1;
        #1;
        chk("c.idle_in_ready", 32'(c_ir), 32'd1);
        next_cycle();
        c_id = 4'h6;
        #1;
        chk("c.w0.out_valid", 32'(c_ov), 32'd1);
        chk("c.w0.out_data", 32'(c_od), 32'h9);
        chk("c.w0.out_index", 32'(c_oi), 32'd0);
        chk("c.w0.out_last", 32'(c_ol), 32'd1);
        chk("c.w0.in_ready", 32'(c_ir), 32'd1);
        next_cycle();
        c_iv = 0; c_ordy = 0;
        #1;
        chk("c.w1.out_data", 32'(c_od), 32'h6);
        chk("c.w1.out_last", 32'(c_ol), 32'd1);
        chk("c.w1.in_ready", 32'(c_ir), 32'd0);
        next_cycle();
        #1;
        chk("c.hold.out_valid", 32'(c_ov), 32'd1);
        chk("c.hold.out_data", 32'(c_od), 32'h6);
        c_ordy = 1;
        #1;
        chk("c.release.in_ready", 32'(c_ir), 32'd1);
        next_cycle();
        #1;
        chk("c.end.out_valid", 32'(c_ov), 32'd0);
        chk("c.end.out_data", 32'(c_od), 32'd0);
        chk("c.end.out_last", 32'(c_ol), 32'd0);
        chk("c.end.busy", 32'(c_busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
